// File: rtl/rsa_seq_pkg.sv
// Shared types and constants for the RSA message-word sequencer.
package rsa_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StHold
  } state_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rsa_word_sequencer_if.sv
// Producer-side input stream and consumer-side result stream of the sequencer.
interface rsa_word_sequencer_if;
  import rsa_seq_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

endinterface

// File: rtl/rsa_word_fifo.sv
// Synchronous power-of-two FIFO with combinational full/empty/head.
module rsa_word_fifo
  import rsa_seq_pkg::cnt_width;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rsa_word_sequencer.sv
// Feeds buffered message words to the modular exponentiator one at a time,
// rejecting out-of-range words and bounding each launch with a watchdog.
module rsa_word_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int unsigned       DEPTH   = 4,
  parameter logic [WORD_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  rsa_word_sequencer_if.slave strm,
  input  logic [WORD_W-1:0] modulus,
  input  logic              keys_ready,
  output logic [WORD_W-1:0] exp_msg,
  output logic              exp_start,
  input  logic              exp_done,
  input  logic [WORD_W-1:0] exp_result,
  output logic              busy
);

  state_e            state_q;
  logic              armed_q;
  logic [WORD_W-1:0] wdog_q, wdog_inc;
  logic [WORD_W-1:0] out_data_q;
  logic              out_err_q, out_valid_q;

  logic              full, empty;
  logic [WORD_W-1:0] head;
  logic              push, pop, reject, timeout, idle_go, launch_end;

  assign strm.in_ready  = !full && !reset;
  assign strm.out_data  = out_data_q;
  assign strm.out_err   = out_err_q;
  assign strm.out_valid = out_valid_q;

  assign push       = strm.in_valid && strm.in_ready;
  assign reject     = (head >= modulus);
  assign wdog_inc   = (wdog_q == '1) ? wdog_q : wdog_q + 16'd1;
  assign timeout    = (wdog_inc >= TIMEOUT);
  assign idle_go    = (state_q == StIdle) && !empty && keys_ready && armed_q;
  assign launch_end = (state_q == StLaunch) && keys_ready && (exp_done || timeout);
  assign pop        = (idle_go && reject) || launch_end;
  assign busy       = (state_q != StIdle) || !empty;

  rsa_word_fifo #(
    .DEPTH (DEPTH),
    .WORD_W(WORD_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(strm.in_data),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      wdog_q      <= '0;
      exp_msg     <= '0;
      exp_start   <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Dwell one cycle with a word visible at the head before acting.
          if (!empty && keys_ready) begin
            if (!armed_q) begin
              armed_q <= 1'b1;
            end else begin
              armed_q <= 1'b0;
              if (reject) begin
                out_data_q  <= head;
                out_err_q   <= 1'b1;
                out_valid_q <= 1'b1;
                state_q     <= StHold;
              end else begin
                exp_msg   <= head;
                exp_start <= 1'b1;
                wdog_q    <= '0;
                state_q   <= StLaunch;
              end
            end
          end else begin
            armed_q <= 1'b0;
          end
        end
        StLaunch: begin
          if (!keys_ready) begin
            exp_start <= 1'b0;
            state_q   <= StIdle;
          end else if (exp_done) begin
            exp_start   <= 1'b0;
            out_data_q  <= exp_result;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end else if (timeout) begin
            exp_start   <= 1'b0;
            out_data_q  <= exp_msg;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end else begin
            wdog_q <= wdog_inc;
          end
        end
        StHold: begin
          if (strm.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
